// File: rtl/router_reg_gen.sv
// Router register stage: header capture, FIFO write path with a small hold buffer, packet check.
// dout/dout_valid are registered (1 cycle direct, 2+ via hold); a full FIFO diverts bytes into the hold buffer and overflow drops them.
module router_reg_gen #(
    parameter int DW         = 8,
    parameter int AW         = 2,
    parameter int HOLD_DEPTH = 2,
    parameter int CHK_MODE   = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pkt_valid,
    input  logic [DW-1:0] data_in,
    input  logic          fifo_full,
    input  logic          detect_add,
    input  logic          lfd_state,
    input  logic          ld_state,
    input  logic          laf_state,
    input  logic          full_state,
    input  logic          rst_int_reg,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          parity_done,
    output logic          low_pkt_valid,
    output logic          error,
    output logic          overflow,
    output logic          hold_empty,
    output logic [7:0]    err_count
);

    localparam int PW = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
    localparam int CW = $clog2(HOLD_DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(HOLD_DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(HOLD_DEPTH);
    localparam logic [AW-1:0] BAD_ADDR = '1;

    logic [DW-1:0] header_reg;
    logic [DW-1:0] int_chk;
    logic [DW-1:0] pkt_chk;
    logic          chk_pending;
    logic [DW-1:0] hold_mem [HOLD_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    logic          hdr_ok;
    logic          has_cand;
    logic [DW-1:0] cand_dat;
    logic          is_chk;
    logic          held;
    logic          pop;
    logic          direct;
    logic          want_push;
    logic          push;
    logic          drop;
    logic          accept;
    logic [DW-1:0] acc_next;

    function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        hdr_ok    = detect_add & pkt_valid & (data_in[AW-1:0] != BAD_ADDR);
        has_cand  = lfd_state | ld_state;
        cand_dat  = lfd_state ? header_reg : data_in;
        is_chk    = ld_state & ~pkt_valid;
        held      = (cnt != '0);
        pop       = ~fifo_full & ~full_state & held & (has_cand | laf_state);
        direct    = has_cand & ~fifo_full & ~held;
        want_push = has_cand & (fifo_full | held);
        // A full buffer still takes a byte when its head leaves in the same cycle.
        push      = want_push & ((cnt != FULL_CNT) | pop);
        drop      = want_push & ~push;
        accept    = direct | push;
        acc_next  = (CHK_MODE == 1) ? (int_chk + cand_dat) : (int_chk ^ cand_dat);
    end

    always_comb begin
        cnt_next = cnt;
        if (push && !pop)
            cnt_next = cnt + 1'b1;
        else if (pop && !push)
            cnt_next = cnt - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            header_reg    <= '0;
            int_chk       <= '0;
            pkt_chk       <= '0;
            chk_pending   <= 1'b0;
            for (int i = 0; i < HOLD_DEPTH; i++) hold_mem[i] <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            cnt           <= '0;
            dout          <= '0;
            dout_valid    <= 1'b0;
            parity_done   <= 1'b0;
            low_pkt_valid <= 1'b0;
            error         <= 1'b0;
            overflow      <= 1'b0;
            hold_empty    <= 1'b1;
            err_count     <= '0;
        end else if (hdr_ok) begin
            // New packet: any leftover held bytes are discarded with the old status.
            header_reg    <= data_in;
            int_chk       <= '0;
            pkt_chk       <= '0;
            chk_pending   <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            cnt           <= '0;
            dout_valid    <= 1'b0;
            parity_done   <= 1'b0;
            low_pkt_valid <= 1'b0;
            error         <= 1'b0;
            hold_empty    <= 1'b1;
        end else begin
            dout_valid <= direct | pop;
            if (direct)
                dout <= cand_dat;
            else if (pop)
                dout <= hold_mem[rd_ptr];
            if (push) begin
                hold_mem[wr_ptr] <= cand_dat;
                wr_ptr           <= nxt_ptr(wr_ptr);
            end
            if (pop)
                rd_ptr <= nxt_ptr(rd_ptr);
            cnt        <= cnt_next;
            hold_empty <= (cnt_next == '0);
            if (drop)
                overflow <= 1'b1;
            if (accept && !is_chk)
                int_chk <= acc_next;
            if (accept && is_chk)
                pkt_chk <= cand_dat;
            chk_pending <= accept & is_chk;
            if (accept && is_chk) begin
                parity_done   <= 1'b1;
                low_pkt_valid <= 1'b1;
            end else if (rst_int_reg) begin
                parity_done   <= 1'b0;
                low_pkt_valid <= 1'b0;
                error         <= 1'b0;
            end
            if (chk_pending) begin
                error <= (pkt_chk != int_chk);
                if ((pkt_chk != int_chk) && (err_count != 8'hFF))
                    err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_router_reg_gen.sv
// Directed bench for router_reg_gen: an XOR-mode and a sum-mode instance driven with the same stimulus.
module tb_router_reg_gen;

    localparam int ST_NONE = 0;
    localparam int ST_DA   = 1;
    localparam int ST_LFD  = 2;
    localparam int ST_LD   = 3;
    localparam int ST_LAF  = 4;
    localparam int ST_FULL = 5;

    logic       clk;
    logic       reset;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       rst_int_reg;

    logic [7:0] x_dout, x_err_count, s_dout, s_err_count;
    logic       x_dout_valid, x_parity_done, x_low_pkt_valid, x_error, x_overflow, x_hold_empty;
    logic       s_dout_valid, s_parity_done, s_low_pkt_valid, s_error, s_overflow, s_hold_empty;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         st;
        logic       pv;
        logic [7:0] d;
        logic       ff;
        logic       ri;
        logic [7:0] e_dout;
        logic       e_vld;
        logic       e_pd;
        logic       e_err;
        logic       e_he;
        logic       e_ovf;
        logic [7:0] e_ec;
    } vec_t;

    vec_t vecs[$];

    router_reg_gen #(.DW(8), .AW(2), .HOLD_DEPTH(2), .CHK_MODE(0)) u_xor (
        .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in), .fifo_full(fifo_full),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .rst_int_reg(rst_int_reg), .dout(x_dout), .dout_valid(x_dout_valid),
        .parity_done(x_parity_done), .low_pkt_valid(x_low_pkt_valid), .error(x_error),
        .overflow(x_overflow), .hold_empty(x_hold_empty), .err_count(x_err_count)
    );

    router_reg_gen #(.DW(8), .AW(2), .HOLD_DEPTH(2), .CHK_MODE(1)) u_sum (
        .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in), .fifo_full(fifo_full),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .rst_int_reg(rst_int_reg), .dout(s_dout), .dout_valid(s_dout_valid),
        .parity_done(s_parity_done), .low_pkt_valid(s_low_pkt_valid), .error(s_error),
        .overflow(s_overflow), .hold_empty(s_hold_empty), .err_count(s_err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, want %02h", name, act, exp);
        end
    endtask

    task automatic drive(input int st, input logic pv, input logic [7:0] d, input logic ff, input logic ri);
        detect_add  = (st == ST_DA);
        lfd_state   = (st == ST_LFD);
        ld_state    = (st == ST_LD);
        laf_state   = (st == ST_LAF);
        full_state  = (st == ST_FULL);
        pkt_valid   = pv;
        data_in     = d;
        fifo_full   = ff;
        rst_int_reg = ri;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int st, input logic pv, input logic [7:0] d, input logic ff, input logic ri,
                       input logic [7:0] ed, input logic ev, input logic epd, input logic eerr,
                       input logic ehe, input logic eovf, input logic [7:0] eec);
        vec_t v;
        v.st = st; v.pv = pv; v.d = d; v.ff = ff; v.ri = ri;
        v.e_dout = ed; v.e_vld = ev; v.e_pd = epd; v.e_err = eerr;
        v.e_he = ehe; v.e_ovf = eovf; v.e_ec = eec;
        vecs.push_back(v);
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] c);
        drive(ST_DA,   1'b1, hdr,   1'b0, 1'b0); tick();
        drive(ST_LFD,  1'b1, 8'h00, 1'b0, 1'b0); tick();
        drive(ST_LD,   1'b1, p0,    1'b0, 1'b0); tick();
        drive(ST_LD,   1'b1, p1,    1'b0, 1'b0); tick();
        drive(ST_LD,   1'b0, c,     1'b0, 1'b0); tick();
        drive(ST_NONE, 1'b0, 8'h00, 1'b0, 1'b0); tick();
    endtask

    initial begin
        reset = 1'b1;
        drive(ST_NONE, 1'b0, 8'h00, 1'b0, 1'b0);
        #1 reset = 1'b0;
        #1;
        chk8("rst.dout", x_dout, 8'h00);
        chk1("rst.dout_valid", x_dout_valid, 1'b0);
        chk1("rst.parity_done", x_parity_done, 1'b0);
        chk1("rst.low_pkt_valid", x_low_pkt_valid, 1'b0);
        chk1("rst.error", x_error, 1'b0);
        chk1("rst.overflow", x_overflow, 1'b0);
        chk1("rst.hold_empty", x_hold_empty, 1'b1);
        chk8("rst.err_count", x_err_count, 8'h00);
        #10 reset = 1'b1;

        //   state    pv    data   ff    ri     dout   vld   pd    err   he    ovf   ec
        // XOR pass: 09 A5 3C, check 90
        add(ST_DA,   1'b1, 8'h09, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        add(ST_LFD,  1'b1, 8'h00, 1'b0, 1'b0, 8'h09, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        add(ST_LD,   1'b1, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        add(ST_LD,   1'b1, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        add(ST_LD,   1'b0, 8'h90, 1'b0, 1'b0, 8'h90, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        add(ST_NONE, 1'b0, 8'h00, 1'b0, 1'b0, 8'h90, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        // XOR fail: check 91
        add(ST_DA,   1'b1, 8'h09, 1'b0, 1'b0, 8'h90, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        add(ST_LFD,  1'b1, 8'h00, 1'b0, 1'b0, 8'h09, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        add(ST_LD,   1'b1, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        add(ST_LD,   1'b1, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        add(ST_LD,   1'b0, 8'h91, 1'b0, 1'b0, 8'h91, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        add(ST_NONE, 1'b0, 8'h00, 1'b0, 1'b0, 8'h91, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
        add(ST_NONE, 1'b0, 8'h00, 1'b0, 1'b0, 8'h91, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
        // invalid address leaves status and header alone; LFD still emits the old header
        add(ST_DA,   1'b1, 8'h0B, 1'b0, 1'b0, 8'h91, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
        add(ST_LFD,  1'b1, 8'h00, 1'b0, 1'b0, 8'h09, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
        add(ST_DA,   1'b1, 8'h09, 1'b0, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
        // hold buffer: A5, 3C held, 77 dropped, 5A pushed while head pops
        add(ST_LFD,  1'b1, 8'h00, 1'b0, 1'b0, 8'h09, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
        add(ST_LD,   1'b1, 8'hA5, 1'b1, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
        add(ST_LD,   1'b1, 8'h3C, 1'b1, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
        add(ST_LD,   1'b1, 8'h77, 1'b1, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
        add(ST_FULL, 1'b1, 8'h00, 1'b1, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
        add(ST_LD,   1'b1, 8'h5A, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
        add(ST_LAF,  1'b1, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
        add(ST_LAF,  1'b1, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1);
        add(ST_LD,   1'b0, 8'hCA, 1'b0, 1'b0, 8'hCA, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1);
        add(ST_NONE, 1'b0, 8'h00, 1'b0, 1'b0, 8'hCA, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1);
        add(ST_NONE, 1'b0, 8'h00, 1'b0, 1'b1, 8'hCA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1);

        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].pv, vecs[i].d, vecs[i].ff, vecs[i].ri);
            tick();
            chk8($sformatf("v%0d.dout", i), x_dout, vecs[i].e_dout);
            chk1($sformatf("v%0d.dout_valid", i), x_dout_valid, vecs[i].e_vld);
            chk1($sformatf("v%0d.parity_done", i), x_parity_done, vecs[i].e_pd);
            chk1($sformatf("v%0d.low_pkt_valid", i), x_low_pkt_valid, vecs[i].e_pd);
            chk1($sformatf("v%0d.error", i), x_error, vecs[i].e_err);
            chk1($sformatf("v%0d.hold_empty", i), x_hold_empty, vecs[i].e_he);
            chk1($sformatf("v%0d.overflow", i), x_overflow, vecs[i].e_ovf);
            chk8($sformatf("v%0d.err_count", i), x_err_count, vecs[i].e_ec);
        end

        // detect_add with a non-empty hold buffer discards the held header
        drive(ST_DA,  1'b1, 8'h09, 1'b0, 1'b0); tick();
        drive(ST_LFD, 1'b1, 8'h00, 1'b1, 1'b0); tick();
        chk1("flush.held", x_hold_empty, 1'b0);
        chk1("flush.no_write", x_dout_valid, 1'b0);
        drive(ST_DA,  1'b1, 8'h09, 1'b0, 1'b0); tick();
        chk1("flush.cleared", x_hold_empty, 1'b1);
        drive(ST_LAF, 1'b1, 8'h00, 1'b0, 1'b0); tick();
        chk1("flush.no_pop", x_dout_valid, 1'b0);

        // sum mode: check byte EA passes sum, fails XOR; 90 the other way round
        send_pkt(8'h09, 8'hA5, 8'h3C, 8'hEA);
        chk1("sum_ok.s_error", s_error, 1'b0);
        chk1("sum_ok.s_parity_done", s_parity_done, 1'b1);
        chk1("sum_ok.x_error", x_error, 1'b1);
        chk8("sum_ok.x_err_count", x_err_count, 8'd2);
        send_pkt(8'h09, 8'hA5, 8'h3C, 8'h90);
        chk1("sum_bad.s_error", s_error, 1'b1);
        chk1("sum_bad.x_error", x_error, 1'b0);
        chk8("sum_bad.s_dout", s_dout, 8'h90);
        chk8("sum_bad.x_err_count", x_err_count, 8'd2);

        // asynchronous reset mid-packet with a byte held
        drive(ST_DA,  1'b1, 8'h09, 1'b0, 1'b0); tick();
        drive(ST_LFD, 1'b1, 8'h00, 1'b0, 1'b0); tick();
        drive(ST_LD,  1'b1, 8'hA5, 1'b1, 1'b0); tick();
        chk1("mid.held", x_hold_empty, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk8("mid.dout", x_dout, 8'h00);
        chk1("mid.dout_valid", x_dout_valid, 1'b0);
        chk1("mid.parity_done", x_parity_done, 1'b0);
        chk1("mid.low_pkt_valid", x_low_pkt_valid, 1'b0);
        chk1("mid.error", x_error, 1'b0);
        chk1("mid.overflow", x_overflow, 1'b0);
        chk1("mid.hold_empty", x_hold_empty, 1'b1);
        chk8("mid.err_count", x_err_count, 8'd0);
        chk1("mid.s_overflow", s_overflow, 1'b0);
        chk1("mid.s_hold_empty", s_hold_empty, 1'b1);
        chk1("mid.s_dout_valid", s_dout_valid, 1'b0);
        chk1("mid.s_low_pkt_valid", s_low_pkt_valid, 1'b0);
        #2 reset = 1'b1;
        drive(ST_LAF, 1'b1, 8'h00, 1'b0, 1'b0); tick();
        chk1("mid.after_vld", x_dout_valid, 1'b0);
        chk1("mid.after_he", x_hold_empty, 1'b1);

        // saturating error counter
        for (int n = 0; n < 255; n++) send_pkt(8'h09, 8'hA5, 8'h3C, 8'h00);
        chk8("sat.at_255", x_err_count, 8'd255);
        send_pkt(8'h09, 8'hA5, 8'h3C, 8'h00);
        chk8("sat.x_stays", x_err_count, 8'd255);
        chk8("sat.s_stays", s_err_count, 8'd255);
        chk1("sat.error", x_error, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/router_reg_gen.md
# router_reg_gen

Parametrised register stage of the packet router, sitting between the router FSM and the per-destination output FIFOs. It captures the header, forwards header, payload and parity bytes to the FIFO write port, and buffers up to HOLD_DEPTH bytes that arrive while the FIFO is full. It accumulates an internal check value using either XOR parity or modulo-2^DW sum, and compares it with the packet's trailing check byte. It flags mismatches and overflow and keeps a saturating error count.

## Interface
- DW, 8: data width in bits.
- AW, 2: destination address bits, held in `data_in[AW-1:0]`. The all-ones address is invalid, so there are 2^AW-1 destinations.
- HOLD_DEPTH, 2: number of entries in the full-condition hold buffer (≥1).
- CHK_MODE, 0: check algorithm. 0 = XOR parity; 1 = modulo-2^DW sum.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- pkt_valid  in  1  source packet-valid; goes low on the check byte.
- data_in  in  DW  source byte.
- fifo_full  in  1  selected output FIFO is full.
- detect_add, lfd_state, ld_state, laf_state, full_state  in  1 each  FSM state decodes (one-hot).
- rst_int_reg  in  1  FSM request to clear packet status.
- dout  out  DW  FIFO write data.
- dout_valid  out  1  FIFO write enable, aligned with `dout`.
- parity_done  out  1  check byte accepted; level signal.
- low_pkt_valid  out  1  end of packet seen.
- error  out  1  check mismatch for the current packet.
- overflow  out  1  sticky: a byte was dropped because the hold buffer was full.
- hold_empty  out  1  hold buffer is empty; the FSM leaves laf_state on this.
- err_count  out  8  saturating count of packets with a check mismatch.

## Operation
- **Header capture.** When `detect_add & pkt_valid & data_in[AW-1:0] != all-ones`:
  - `header_reg <= data_in`.
  - `int_chk`, `pkt_chk`, `parity_done`, `low_pkt_valid`, `error`, and the hold pointers and count are all cleared.
  - `overflow` and `err_count` are not affected.
  - If the address is all-ones, nothing changes.
- **Write candidate.** Each cycle there is at most one candidate byte:
  - `lfd_state` → `header_reg`.
  - `ld_state` → `data_in`.
  - In any other state there is no candidate.
- **Candidate routing.**
  - If a candidate exists, `!fifo_full` and the hold buffer is empty: the candidate goes straight to `dout` and `dout_valid` = 1.
  - If a candidate exists and (`fifo_full` or the hold buffer is non-empty): the candidate is pushed to the hold tail. In the same cycle, if `!fifo_full`, the hold head is popped to `dout`. Order is strictly FIFO.
  - If the hold buffer is full and no pop happens in that cycle, the candidate is dropped and `overflow` <= 1. A dropped byte is not accumulated.
- **laf_state / full_state.**
  - `laf_state`: if `!fifo_full` and the hold buffer is non-empty, pop one byte to `dout`.
  - `full_state`: no pop and no push.
- **Accumulation.** Every byte is accumulated when it is accepted (written out or pushed), never when it is popped.
  - Header and payload bytes (`pkt_valid`=1) update `int_chk` with XOR (CHK_MODE 0) or a sum truncated to DW (CHK_MODE 1).
  - The check byte (`ld_state & !pkt_valid`) is not accumulated. It is forwarded like any other byte and loaded into `pkt_chk`.
- **End of packet.** When the check byte is accepted, `parity_done` <= 1 and `low_pkt_valid` <= 1. Both hold until `detect_add` or `rst_int_reg`.
- **Error.** In the cycle after `parity_done` rises:
  - `error <= (pkt_chk != int_chk)`.
  - If there is a mismatch, `err_count` increments, saturating at 255.
  - `error` holds until `detect_add` or `rst_int_reg`.
- **Clearing overflow.** `overflow` is cleared only by reset.

## Timing
- Reset (asynchronous, active-low): every output is 0 except `hold_empty` = 1. All internal registers are 0.
- Direct path latency: `dout` and `dout_valid` are registered, so they change one cycle after the candidate cycle. `dout_valid` is 0 in any cycle with no write.
- Through the hold buffer, the minimum latency is 2 cycles (push, then pop).
- Push and pop in the same cycle leave the count unchanged.
- `parity_done` rises one cycle after check-byte acceptance. `error` and `err_count` update one cycle after that.
- `hold_empty` is registered and reflects the count after the current edge.
- Reset asserted mid-packet clears everything at once. No partial byte is emitted after reset is released.
- If `detect_add` arrives while the hold buffer is non-empty, the held bytes are discarded. The FSM must not do this; the bench checks that the block clears the buffer anyway.

## Test plan
- **XOR pass.** DW=8, AW=2, CHK_MODE=0. Send header 0x09, payload 0xA5, 0x3C, check byte 0x90, with fifo_full=0.
  - Required: `dout` sequence 0x09, 0xA5, 0x3C, 0x90 with `dout_valid` high for 4 cycles.
  - Required: `parity_done`=1, `error`=0, `err_count`=0.
- **XOR fail.** Same packet with check byte 0x91.
  - Required: `error`=1 two cycles after the check byte.
  - Required: `err_count`=1; `error` clears on the next `detect_add`.
- **Invalid address.** Header 0x0B (address 2'b11) with `detect_add` high.
  - Required: `header_reg`, `dout` and `int_chk` unchanged; no `dout_valid`.
- **Hold buffer.** HOLD_DEPTH=2. Hold fifo_full=1 for payloads 0xA5 and 0x3C, then release it in laf_state.
  - Required: `hold_empty`=0 while full. After release, 0xA5 then 0x3C appear in order, then `hold_empty`=1.
  - Required: a third byte while still full sets `overflow`=1, and that byte is never written.
- **Sum mode.** CHK_MODE=1, header 0x09, payload 0xA5, 0x3C, check byte 0xEA.
  - Required: `error`=0. Repeating with check byte 0x90 gives `error`=1.
- **Reset and saturation.** Assert reset mid-payload.
  - Required: all outputs 0 and `hold_empty`=1 immediately, without waiting for a clock edge.
  - Required: after 256 failing packets, `err_count` stays at 255.
